// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: DEPTH-entry FIFO that drains words one at a time into UART_Tx_v_2.
// Define UART_FEEDER_OVF_EN to get the sticky ovf_err flag on dropped writes.
module uart_tx_feeder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     flush,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   fifo_count,
  input  logic                     UART_Tx_READY_BUSY,
  output logic                     UART_Tx_RQST,
  output logic [DATA_W-1:0]        Tx_DATA,
  output logic                     ovf_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic rqst_q, rqst_d, push, pop;
  assign fifo_full  = count_q == (AW+1)'(DEPTH);
  assign fifo_empty = count_q == '0;
  assign fifo_count = count_q;
  assign UART_Tx_RQST = rqst_q;
  assign Tx_DATA = tx_data_q;
  // flush outranks a same-cycle write; pops only come from IDLE
  assign push = wr_en && !fifo_full && !flush;
  assign pop  = state_q == IDLE && !fifo_empty && UART_Tx_READY_BUSY;
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d  = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_comb begin
    state_d   = state_q;
    rqst_d    = rqst_q;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: if (pop) begin
        state_d   = REQ;
        rqst_d    = 1'b1;
        tx_data_d = mem_q[rd_ptr_q];
      end
      REQ: if (!UART_Tx_READY_BUSY) begin
        state_d = BUSY;
        rqst_d  = 1'b0;
      end
      BUSY: if (UART_Tx_READY_BUSY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rqst_q    <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rqst_q    <= rqst_d;
      tx_data_q <= tx_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
`ifdef UART_FEEDER_OVF_EN
  logic ovf_q, ovf_d;
  always_comb begin
    ovf_d = flush ? 1'b0 : (ovf_q || (wr_en && fifo_full));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed and randomized checks of uart_tx_feeder against a
// queue-based scoreboard and a behavioural transmitter model.
module tb_uart_tx_feeder;
  localparam int DEPTH = 8;
`ifdef UART_FEEDER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0, flush = 1'b0;
  logic [7:0] wr_data = '0;
  logic fifo_full, fifo_empty, rqst, ovf_err, ready;
  logic [3:0] fifo_count;
  logic [7:0] tx_data;
  logic tx_auto = 1'b0, man_ready = 1'b1, model_ready = 1'b1, busy_rand = 1'b0;
  int tx_busy = 20, busy_cnt = 0, max_cnt = 0;
  int errors = 0, checks = 0;
  logic [7:0] cap_q[$], exp_q[$];

  uart_tx_feeder #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .UART_Tx_READY_BUSY(ready), .UART_Tx_RQST(rqst), .Tx_DATA(tx_data), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;
  assign ready = tx_auto ? model_ready : man_ready;

  // Transmitter model: accepts a request when ready, then stays busy for a while
  always @(negedge clk) begin
    if (!rst) begin
      model_ready <= 1'b1;
      busy_cnt <= 0;
    end else if (tx_auto) begin
      if (model_ready && rqst) begin
        cap_q.push_back(tx_data);
        model_ready <= 1'b0;
        busy_cnt <= busy_rand ? int'($urandom_range(0, 6)) : tx_busy;
      end else if (!model_ready) begin
        if (busy_cnt == 0) model_ready <= 1'b1;
        else busy_cnt <= busy_cnt - 1;
      end
    end
  end

  always @(negedge clk) if (int'(fifo_count) > max_cnt) max_cnt <= int'(fifo_count);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_req();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (rqst) begin
        ok = 1'b1;
        break;
      end
    end
    chk("req_timeout", 32'(ok), 1);
  endtask

  initial begin
    #1;
    chk("rst_rqst", 32'(rqst), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // single word, latency 2
    push(8'hA5);
    chk("single_rqst_early", 32'(rqst), 0);
    @(negedge clk);
    chk("single_rqst", 32'(rqst), 1);
    chk("single_data", 32'(tx_data), 32'hA5);
    chk("single_empty", 32'(fifo_empty), 1);
    man_ready = 1'b0;
    @(negedge clk);
    chk("single_drop", 32'(rqst), 0);
    chk("single_hold", 32'(tx_data), 32'hA5);
    man_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("single_idle", 32'(rqst), 0);

    // burst fill then overflow with transmitter held busy
    man_ready = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk("burst_full", 32'(fifo_full), 1);
    chk("burst_count", 32'(fifo_count), 8);
    chk("pre_ovf", 32'(ovf_err), 0);
    push(8'hFF);
    chk("ovf_count", 32'(fifo_count), 8);
    chk("ovf_full", 32'(fifo_full), 1);
    chk("ovf_flag", 32'(ovf_err), 32'(OVF_EN));
    cap_q.delete();
    tx_busy = 20;
    tx_auto = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wait_req();
      chk("burst_data", 32'(tx_data), 32'(i));
      chk("burst_step", 32'(fifo_count), 32'(8 - i));
    end
    repeat (30) @(negedge clk);
    chk("burst_empty", 32'(fifo_empty), 1);
    chk("burst_ncap", 32'(cap_q.size()), 8);
    for (int i = 0; i < cap_q.size(); i++) chk("burst_cap", 32'(cap_q[i]), 32'(i + 1));
    chk("ovf_sticky", 32'(ovf_err), 32'(OVF_EN));

    // flush while a word is in flight
    cap_q.delete();
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
    chk("flush_pre", 32'(fifo_count), 5);
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    @(negedge clk);
    flush = 1'b0;
    wr_en = 1'b0;
    chk("flush_count", 32'(fifo_count), 0);
    chk("flush_empty", 32'(fifo_empty), 1);
    chk("flush_ovf", 32'(ovf_err), 0);
    repeat (60) @(negedge clk);
    chk("flush_ncap", 32'(cap_q.size()), 1);
    if (cap_q.size() > 0) chk("flush_inflight", 32'(cap_q[0]), 32'h10);
    chk("flush_norq", 32'(rqst), 0);

    // wrap: 3 rounds of 6 writes / 6 drains
    tx_busy = 2;
    for (int r = 0; r < 3; r++) begin
      cap_q.delete();
      for (int k = 0; k < 6; k++) push(8'(16 * r + k + 32));
      for (int i = 0; i < 300 && cap_q.size() < 6; i++) @(negedge clk);
      chk("wrap_ncap", 32'(cap_q.size()), 6);
      for (int k = 0; k < cap_q.size(); k++) chk("wrap_data", 32'(cap_q[k]), 32'(16 * r + k + 32));
    end

    // randomized traffic against the scoreboard
    cap_q.delete();
    exp_q.delete();
    busy_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1 && exp_q.size() - cap_q.size() < DEPTH) begin
        logic [7:0] d = 8'($urandom);
        exp_q.push_back(d);
        push(d);
      end else @(negedge clk);
    end
    for (int i = 0; i < 3000 && cap_q.size() < exp_q.size(); i++) @(negedge clk);
    chk("rand_ncap", 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) chk("rand_data", 32'(cap_q[i]), 32'(exp_q[i]));
    repeat (12) @(negedge clk);
    chk("rand_empty", 32'(fifo_empty), 1);
    chk("max_count", 32'(max_cnt <= DEPTH), 1);

    // asynchronous reset mid-REQ
    busy_rand = 1'b0;
    man_ready = 1'b1;
    tx_auto = 1'b0;
    @(negedge clk);
    push(8'h3C);
    push(8'h4D);
    push(8'h5E);
    chk("mid_rqst", 32'(rqst), 1);
    chk("mid_data", 32'(tx_data), 32'h3C);
    chk("mid_count", 32'(fifo_count), 2);
    #2 rst = 1'b0;
    #1;
    chk("arst_rqst", 32'(rqst), 0);
    chk("arst_data", 32'(tx_data), 0);
    chk("arst_empty", 32'(fifo_empty), 1);
    chk("arst_count", 32'(fifo_count), 0);
    chk("arst_full", 32'(fifo_full), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rqst", 32'(rqst), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
